// File: rtl/i2c_byte_master.sv
// Byte-level I2C master driven by a chaining controller: START/Sr, address, data bursts, STOP.
// Define CLOCK_STRETCH_EN to let a slave stretch SCL low during the high half of each bit.
`timescale 1ns/1ps
module i2c_byte_master #(
  parameter int SYS_CLK_HZ = 50_000_000,
  parameter int BUS_HZ     = 100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data_wr,
  output logic       busy,
  output logic [7:0] data_rd,
  output logic       ack_error,
  inout  wire        scl,
  inout  wire        sda
);

  localparam int DIV   = SYS_CLK_HZ / (4 * BUS_HZ);
  localparam int CNT_W = $clog2(4 * DIV);

  typedef enum logic [3:0] {
    READY, START, COMMAND, SLV_ACK1, WR, RD, SLV_ACK2, MSTR_ACK, STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       addr_rw_q, addr_rw_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       data_rd_q, data_rd_d;
  logic             busy_q, busy_d;
  logic             ack_error_q, ack_error_d;
  logic             scl_drv_q, scl_drv_d;
  logic             sda_drv_q, sda_drv_d;
  logic             stop_sent_q, stop_sent_d;

  logic       stall;
  logic       tick0, tick1, tick2, tick3;
  logic       same_cmd;
  logic [2:0] bit_nxt;
  logic       sda_in;

  assign sda_in   = sda;
  assign same_cmd = ({addr, rw} == addr_rw_q);
  assign bit_nxt  = bit_cnt_q - 3'd1;

  // Divider; with stretching enabled it holds in the high half while a slave keeps SCL low.
  always_comb begin
    stall = 1'b0;
`ifdef CLOCK_STRETCH_EN
    stall = (cnt_q >= CNT_W'(2 * DIV)) && !scl_drv_q && (scl == 1'b0);
`endif
    cnt_d = cnt_q;
    if (!stall) cnt_d = (cnt_q == CNT_W'(4 * DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
  end

  assign tick0 = !stall && (cnt_q == '0);
  assign tick1 = !stall && (cnt_q == CNT_W'(DIV));
  assign tick2 = !stall && (cnt_q == CNT_W'(2 * DIV));
  assign tick3 = !stall && (cnt_q == CNT_W'(3 * DIV));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_rw_d   = addr_rw_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    data_rd_d   = data_rd_q;
    busy_d      = busy_q;
    ack_error_d = ack_error_q;
    scl_drv_d   = scl_drv_q;
    sda_drv_d   = sda_drv_q;
    stop_sent_d = stop_sent_q;

    if (tick0) scl_drv_d = (state_q != READY) && (state_q != STOP);
    if (tick2) scl_drv_d = 1'b0;
    if (state_q == READY && (tick0 || tick2 || tick3)) busy_d = 1'b0;

    // SCL is high here: START/STOP edges, ACK sampling and read sampling.
    if (tick3) begin
      case (state_q)
        START: begin
          sda_drv_d   = 1'b1;
          ack_error_d = 1'b0;
        end
        SLV_ACK1, SLV_ACK2: if (sda_in) ack_error_d = 1'b1;
        RD: rx_d[bit_cnt_q] = sda_in;
        STOP: begin
          if (!stop_sent_q) begin
            sda_drv_d   = 1'b0;
            stop_sent_d = 1'b1;
          end else begin
            stop_sent_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = READY;
          end
        end
        default: ;
      endcase
    end

    if (tick1) begin
      case (state_q)
        READY: begin
          if (ena) begin
            addr_rw_d = {addr, rw};
            tx_d      = data_wr;
            busy_d    = 1'b1;
            sda_drv_d = 1'b0;
            state_d   = START;
          end else begin
            busy_d = 1'b0;
          end
        end
        START: begin
          sda_drv_d = ~addr_rw_q[7];
          bit_cnt_d = 3'd7;
          state_d   = COMMAND;
        end
        COMMAND: begin
          bit_cnt_d = bit_nxt;
          if (bit_cnt_q == 3'd0) begin
            sda_drv_d = 1'b0;
            state_d   = SLV_ACK1;
          end else begin
            sda_drv_d = ~addr_rw_q[bit_nxt];
          end
        end
        SLV_ACK1: begin
          if (addr_rw_q[0]) begin
            sda_drv_d = 1'b0;
            state_d   = RD;
          end else begin
            sda_drv_d = ~tx_q[7];
            state_d   = WR;
          end
        end
        WR: begin
          bit_cnt_d = bit_nxt;
          if (bit_cnt_q == 3'd0) begin
            sda_drv_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = SLV_ACK2;
          end else begin
            sda_drv_d = ~tx_q[bit_nxt];
          end
        end
        RD: begin
          bit_cnt_d = bit_nxt;
          if (bit_cnt_q == 3'd0) begin
            data_rd_d = rx_q;
            busy_d    = 1'b0;
            sda_drv_d = ena && same_cmd;
            state_d   = MSTR_ACK;
          end
        end
        // Handshake: the controller's ena/addr/rw at the end of the ack bit picks the next step.
        SLV_ACK2, MSTR_ACK: begin
          if (ena) begin
            busy_d = 1'b1;
            tx_d   = data_wr;
            if (same_cmd) begin
              sda_drv_d = addr_rw_q[0] ? 1'b0 : ~data_wr[7];
              state_d   = addr_rw_q[0] ? RD : WR;
            end else begin
              addr_rw_d = {addr, rw};
              sda_drv_d = 1'b0;
              state_d   = START;
            end
          end else begin
            sda_drv_d = 1'b1;
            state_d   = STOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= READY;
      cnt_q       <= '0;
      bit_cnt_q   <= 3'd7;
      addr_rw_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      data_rd_q   <= '0;
      busy_q      <= 1'b1;
      ack_error_q <= 1'b0;
      scl_drv_q   <= 1'b0;
      sda_drv_q   <= 1'b0;
      stop_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_rw_q   <= addr_rw_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      data_rd_q   <= data_rd_d;
      busy_q      <= busy_d;
      ack_error_q <= ack_error_d;
      scl_drv_q   <= scl_drv_d;
      sda_drv_q   <= sda_drv_d;
      stop_sent_q <= stop_sent_d;
    end
  end

  assign scl       = scl_drv_q ? 1'b0 : 1'bz;
  assign sda       = sda_drv_q ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign data_rd   = data_rd_q;
  assign ack_error = ack_error_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master: a behavioural slave at 0x50 logs the bus traffic.
`timescale 1ns/1ps
module tb_i2c_byte_master;

  localparam int SYS_CLK_HZ = 4_000_000;
  localparam int BUS_HZ     = 100_000;
  localparam int DIV        = SYS_CLK_HZ / (4 * BUS_HZ);
  localparam int LIMIT      = 4000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ena;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] data_wr;
  logic       busy;
  logic [7:0] data_rd;
  logic       ack_error;
  wire        scl;
  wire        sda;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  pullup (scl);
  pullup (sda);

  i2c_byte_master #(.SYS_CLK_HZ(SYS_CLK_HZ), .BUS_HZ(BUS_HZ)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .addr(addr), .rw(rw), .data_wr(data_wr),
    .busy(busy), .data_rd(data_rd), .ack_error(ack_error), .scl(scl), .sda(sda)
  );

  // Slave model state and bus log
  logic       slaveSdaLow = 1'b0;
  logic       prevScl = 1'b1;
  logic       prevSda = 1'b1;
  int         bitpos = -1;
  bit         addrPhase = 1'b0;
  bit         reading = 1'b0;
  bit         matched = 1'b0;
  bit         slaveAcking = 1'b0;
  logic [7:0] shiftReg = 8'h00;
  logic [7:0] txByte = 8'h00;
  int         romIdx = 0;
  int         sclRises = 0;
  int         startCnt = 0;
  int         stopCnt = 0;
  int         stopsAtLastStart = 0;
  int         busyFalls = 0;
  time        lastStartTime = 0;
  logic [7:0] addrLog[$];
  logic [7:0] wrLog[$];
  logic       mackLog[$];

  assign sda = slaveSdaLow ? 1'b0 : 1'bz;

  function automatic logic [7:0] romByte(input int idx);
    case (idx)
      0: return 8'h11;
      1: return 8'h22;
      2: return 8'h33;
      3: return 8'h5A;
      default: return 8'hFF;
    endcase
  endfunction

  // Slave reacts to START/STOP and SCL edges; it drives SDA only while SCL is low.
  always @(scl or sda) begin
    if (prevScl === 1'b1 && scl === 1'b1 && prevSda === 1'b1 && sda === 1'b0) begin
      startCnt++;
      stopsAtLastStart = stopCnt;
      lastStartTime = $time;
      bitpos = -1; addrPhase = 1'b1; reading = 1'b0; matched = 1'b0;
      slaveAcking = 1'b0; slaveSdaLow = 1'b0;
    end else if (prevScl === 1'b1 && scl === 1'b1 && prevSda === 1'b0 && sda === 1'b1) begin
      stopCnt++;
      bitpos = -1; addrPhase = 1'b0; reading = 1'b0; matched = 1'b0;
      slaveAcking = 1'b0; slaveSdaLow = 1'b0;
    end else if (prevScl !== 1'b1 && scl === 1'b1) begin
      sclRises++;
      if (bitpos >= 0 && bitpos < 8 && !reading) shiftReg = {shiftReg[6:0], sda};
      else if (bitpos == 8 && reading && !slaveAcking) begin
        mackLog.push_back(sda);
        if (sda !== 1'b0) reading = 1'b0;
      end
    end else if (prevScl === 1'b1 && scl !== 1'b1) begin
      if (bitpos == -1) begin
        bitpos = 0;
      end else if (bitpos == 7) begin
        bitpos = 8; slaveAcking = 1'b0; slaveSdaLow = 1'b0;
        if (addrPhase) begin
          addrLog.push_back(shiftReg);
          addrPhase = 1'b0;
          matched = (shiftReg[7:1] == 7'h50);
          reading = matched && shiftReg[0];
          slaveAcking = matched; slaveSdaLow = matched;
        end else if (!reading && matched) begin
          wrLog.push_back(shiftReg);
          slaveAcking = 1'b1; slaveSdaLow = 1'b1;
        end
      end else if (bitpos == 8) begin
        bitpos = 0; slaveAcking = 1'b0; slaveSdaLow = 1'b0;
        if (reading) begin
          txByte = romByte(romIdx);
          romIdx++;
          slaveSdaLow = !txByte[7];
        end
      end else if (bitpos >= 0) begin
        bitpos++;
        slaveSdaLow = reading ? !txByte[7 - bitpos] : 1'b0;
      end
    end
    prevScl = scl;
    prevSda = sda;
  end

  always @(negedge busy) busyFalls++;

  int bRises, bStarts, bStops, bFalls, bAddr, bWr, bMack;
  time t0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [7:0] d, input logic e);
    @(negedge clk);
    addr = a; rw = r; data_wr = d; ena = e;
  endtask

  task automatic takeSnapshot();
    bRises = sclRises; bStarts = startCnt; bStops = stopCnt; bFalls = busyFalls;
    bAddr = addrLog.size(); bWr = wrLog.size(); bMack = mackLog.size();
  endtask

  task automatic waitBusy(input logic level, input string tag);
    int n = 0;
    while (busy !== level && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, busy, level);
  endtask

  task automatic waitStop(input string tag);
    int n = 0;
    while (stopCnt == bStops && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, stopCnt - bStops, 1);
    repeat (12 * DIV) @(negedge clk);
  endtask

  task automatic writeByte(input logic [6:0] a, input logic [7:0] d, input string tag);
    applyStimulus(a, 1'b0, d, 1'b1);
    waitBusy(1'b1, {tag, "Rise"});
    applyStimulus(a, 1'b0, d, 1'b0);
    waitBusy(1'b0, {tag, "Fall"});
  endtask

  initial begin
    int n;
    reset_n = 1'b0; ena = 1'b0; addr = '0; rw = 1'b0; data_wr = '0;
    repeat (5) @(negedge clk);
    checkOutput("rstBusy", busy, 1'b1);
    checkOutput("rstScl", scl, 1'b1);
    checkOutput("rstSda", sda, 1'b1);
    checkOutput("rstDataRd", data_rd, 8'h00);
    checkOutput("rstAckErr", ack_error, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idleBusy", busy, 1'b0);

    // Single write 0xA5 to 0x50
    takeSnapshot();
    applyStimulus(7'h50, 1'b0, 8'hA5, 1'b1);
    waitBusy(1'b1, "wrRise");
    t0 = $time;
    applyStimulus(7'h50, 1'b0, 8'hA5, 1'b0);
    waitBusy(1'b0, "wrFall");
    checkOutput("wrSclRises", sclRises - bRises, 17);
    checkOutput("wrStartLat", ((lastStartTime - t0) / 10) <= 4 * DIV, 1'b1);
    waitStop("wrStop");
    checkOutput("wrAddr", addrLog[bAddr], 8'hA0);
    checkOutput("wrData", wrLog[bWr], 8'hA5);
    checkOutput("wrStarts", startCnt - bStarts, 1);
    checkOutput("wrAckErr", ack_error, 1'b0);
    checkOutput("wrBusyFalls", busyFalls - bFalls, 1);

    // Burst read of three bytes from 0x50
    takeSnapshot();
    applyStimulus(7'h50, 1'b1, 8'h00, 1'b1);
    waitBusy(1'b1, "rdRise1");
    waitBusy(1'b0, "rdFall1");
    checkOutput("rdByte1", data_rd, 8'h11);
    waitBusy(1'b1, "rdRise2");
    waitBusy(1'b0, "rdFall2");
    checkOutput("rdByte2", data_rd, 8'h22);
    waitBusy(1'b1, "rdRise3");
    applyStimulus(7'h50, 1'b1, 8'h00, 1'b0);
    waitBusy(1'b0, "rdFall3");
    checkOutput("rdByte3", data_rd, 8'h33);
    waitStop("rdStop");
    checkOutput("rdAddr", addrLog[bAddr], 8'hA1);
    checkOutput("rdMack1", mackLog[bMack], 1'b0);
    checkOutput("rdMack2", mackLog[bMack + 1], 1'b0);
    checkOutput("rdMack3", mackLog[bMack + 2], 1'b1);
    checkOutput("rdBusyFalls", busyFalls - bFalls, 3);

    // Write then repeated START into a read
    takeSnapshot();
    applyStimulus(7'h50, 1'b0, 8'h00, 1'b1);
    waitBusy(1'b1, "srRise1");
    waitBusy(1'b0, "srFall1");
    applyStimulus(7'h50, 1'b1, 8'h00, 1'b1);
    waitBusy(1'b1, "srRise2");
    applyStimulus(7'h50, 1'b1, 8'h00, 1'b0);
    waitBusy(1'b0, "srFall2");
    checkOutput("srDataRd", data_rd, 8'h5A);
    waitStop("srStop");
    checkOutput("srStarts", startCnt - bStarts, 2);
    checkOutput("srNoStop", stopsAtLastStart - bStops, 0);
    checkOutput("srAddr1", addrLog[bAddr], 8'hA0);
    checkOutput("srAddr2", addrLog[bAddr + 1], 8'hA1);
    checkOutput("srWrData", wrLog[bWr], 8'h00);
    checkOutput("srMack", mackLog[bMack], 1'b1);

    // NACK from an absent slave at 0x3C, then cleared by the next START
    takeSnapshot();
    writeByte(7'h3C, 8'h77, "nack");
    checkOutput("nackErr", ack_error, 1'b1);
    checkOutput("nackAddr", addrLog[bAddr], 8'h78);
    waitStop("nackStop");
    checkOutput("nackHold", ack_error, 1'b1);
    takeSnapshot();
    applyStimulus(7'h50, 1'b0, 8'h3C, 1'b1);
    waitBusy(1'b1, "clrRise");
    applyStimulus(7'h50, 1'b0, 8'h3C, 1'b0);
    checkOutput("clrStillSet", ack_error, 1'b1);
    repeat (4 * DIV + 2) @(negedge clk);
    checkOutput("clrAtStart", ack_error, 1'b0);
    waitBusy(1'b0, "clrFall");
    waitStop("clrStop");
    checkOutput("clrData", wrLog[bWr], 8'h3C);
    checkOutput("clrAckErr", ack_error, 1'b0);

    // Reset during data bit 4 (0xC3 bit 4 is 0, so SDA is driven low)
    takeSnapshot();
    applyStimulus(7'h50, 1'b0, 8'hC3, 1'b1);
    waitBusy(1'b1, "midRise");
    applyStimulus(7'h50, 1'b0, 8'hC3, 1'b0);
    n = 0;
    while (sclRises - bRises < 13 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midReach", sclRises - bRises, 13);
    repeat (25) @(negedge clk);
    checkOutput("midPreScl", scl, 1'b0);
    checkOutput("midPreSda", sda, 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("midScl", scl, 1'b1);
    checkOutput("midSda", sda, 1'b1);
    checkOutput("midBusy", busy, 1'b1);
    checkOutput("midDataRd", data_rd, 8'h00);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (8 * DIV) @(negedge clk);
    takeSnapshot();
    writeByte(7'h50, 8'h96, "post");
    waitStop("postStop");
    checkOutput("postAddr", addrLog[bAddr], 8'hA0);
    checkOutput("postData", wrLog[bWr], 8'h96);
    checkOutput("postAckErr", ack_error, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
